// File: rtl/reg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank
//  Purpose  : Parametrised register-file bank with a valid/ready command port,
//             registered dual read ports and a self-timed sequential clear
//             sweep that also runs automatically after reset.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_bank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    // Command opcodes
    localparam logic [1:0] c_OP_WRITE      = 2'b00;
    localparam logic [1:0] c_OP_READ_WRITE = 2'b01;
    localparam logic [1:0] c_OP_CLEAR      = 2'b10;
    localparam logic [1:0] c_OP_READ       = 2'b11;

    // FSM encoding
    localparam logic [0:0] c_ST_IDLE     = 1'b0;
    localparam logic [0:0] c_ST_CLEARING = 1'b1;

    // Last sweep index; reaching it ends the clear
    localparam logic [ADDR_W-1:0] c_LAST_IDX = {ADDR_W{1'b1}};

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_rd_cmd;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;

    // A command only counts when the handshake completes in IDLE
    assign w_accept = cmd_valid && cmd_ready;
    assign w_rd_cmd = w_accept && ((cmd_op == c_OP_READ) || (cmd_op == c_OP_READ_WRITE));

    // State register; reset lands in CLEARING so the array is swept before use
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_CLEARING;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: CLEAR starts a sweep, the last entry ends it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept && (cmd_op == c_OP_CLEAR)) begin
                    w_state_nxt = c_ST_CLEARING;
                end
            end
            c_ST_CLEARING: begin
                if (r_clr_idx == c_LAST_IDX) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_CLEARING;
        endcase
    end

    // Output decode: handshake status and the single memory write port
    always_comb begin
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        w_mem_we    = 1'b0;
        w_mem_waddr = r_clr_idx;
        w_mem_wdata = '0;
        case (r_state)
            c_ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (w_accept && ((cmd_op == c_OP_WRITE) || (cmd_op == c_OP_READ_WRITE))) begin
                    w_mem_we    = 1'b1;
                    w_mem_waddr = wr_addr;
                    w_mem_wdata = wr_data;
                end
            end
            c_ST_CLEARING: begin
                w_mem_we    = 1'b1;
                w_mem_waddr = r_clr_idx;
                w_mem_wdata = '0;
            end
            default: begin
                cmd_ready = 1'b0;
                busy      = 1'b1;
            end
        endcase
    end

    // Sweep index: restarts at 0 on CLEAR, advances every sweep cycle and wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_idx <= '0;
        end else if (r_state == c_ST_CLEARING) begin
            r_clr_idx <= r_clr_idx + 1'b1;
        end else if (w_accept && (cmd_op == c_OP_CLEAR)) begin
            r_clr_idx <= '0;
        end
    end

    // Storage array; contents are only ever changed on a clock edge
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Registered read ports; sample the pre-write contents for read-before-write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            rd_valid <= w_rd_cmd;
            if (w_rd_cmd) begin
                rd_data_a <= r_mem[rd_addr_a];
                rd_data_b <= r_mem[rd_addr_b];
            end
        end
    end

endmodule
`default_nettype wire
